// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a 16:1 mux select across enabled channels, one sample per channel (MUX_SCAN_CONTINUOUS_EN wraps the scan).
// Latency: SETTLE_CYCLES edges from a sel change to out_valid; one edge from handshake to the next sel.
// Backpressure: sample and sel frozen in HOLD until out_valid && out_ready; stop aborts from any busy state.
module mux_scan_ctrl #(
    parameter int INPUT_BIT_LENGTH = 1,
    parameter int SETTLE_CYCLES    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic [15:0]                 chan_mask,
    output logic [3:0]                  sel,
    input  logic [INPUT_BIT_LENGTH-1:0] mux_z,
    output logic [INPUT_BIT_LENGTH-1:0] out_data,
    output logic [3:0]                  out_chan,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

    localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [15:0]                 r_mask;
    logic [3:0]                  r_sel;
    logic [3:0]                  r_cnt;
    logic [INPUT_BIT_LENGTH-1:0] r_out_data;
    logic [3:0]                  r_out_chan;
    logic                        r_out_valid;
    logic                        r_done;

    logic                        w_mask_ld;
    logic                        w_load;
    logic [3:0]                  w_sel_nxt;
    logic                        w_capture;
    logic                        w_release;
    logic                        w_abort;
    logic                        w_done_nxt;
    logic [4:0]                  w_start_hit;
    logic [4:0]                  w_next_hit;
`ifdef MUX_SCAN_CONTINUOUS_EN
    logic [4:0]                  w_wrap_hit;
`endif

    // Returns {found, index} of the lowest set bit of m at or above 'from'.
    function automatic logic [4:0] f_find(input logic [15:0] m, input logic [4:0] from);
        f_find = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] && (5'(i) >= from)) begin
                f_find = {1'b1, 4'(i)};
            end
        end
    endfunction

    assign w_start_hit = f_find(chan_mask, 5'd0);
    assign w_next_hit  = f_find(r_mask, {1'b0, r_sel} + 5'd1);
`ifdef MUX_SCAN_CONTINUOUS_EN
    assign w_wrap_hit  = f_find(r_mask, 5'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_ld   = 1'b0;
        w_load      = 1'b0;
        w_sel_nxt   = r_sel;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_abort     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mask_ld = 1'b1;
                    if (w_start_hit[4]) begin
                        w_load      = 1'b1;
                        w_sel_nxt   = w_start_hit[3:0];
                        w_state_nxt = S_SETTLE;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (stop) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == LP_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (stop) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (out_ready) begin
                    w_release = 1'b1;
                    if (w_next_hit[4]) begin
                        w_load      = 1'b1;
                        w_sel_nxt   = w_next_hit[3:0];
                        w_state_nxt = S_SETTLE;
                    end else begin
`ifdef MUX_SCAN_CONTINUOUS_EN
                        if (w_wrap_hit[4]) begin
                            w_load      = 1'b1;
                            w_sel_nxt   = w_wrap_hit[3:0];
                            w_state_nxt = S_SETTLE;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_done_nxt  = 1'b1;
                        end
`else
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
`endif
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // sel only moves on SETTLE entry, so the mux sees one clean transition per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask      <= 16'd0;
            r_sel       <= 4'd0;
            r_cnt       <= 4'd0;
            r_out_data  <= '0;
            r_out_chan  <= 4'd0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_mask_ld) begin
                r_mask <= chan_mask;
            end
            if (w_load) begin
                r_sel <= w_sel_nxt;
                r_cnt <= 4'd0;
            end else if ((r_state == S_SETTLE) && !w_capture) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_capture) begin
                r_out_data  <= mux_z;
                r_out_chan  <= r_sel;
                r_out_valid <= 1'b1;
            end else if (w_abort || w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
    assign done      = r_done;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: two instances (settle 1 and settle 3) with the mux modelled as mux_z = sel.
module tb_mux_scan_ctrl;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic        stop = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] chan_mask = 16'd0;

    logic [3:0]   sel1, chan1, sel3, chan3;
    logic [W-1:0] data1, data3, mux_z1, mux_z3;
    logic         valid1, busy1, done1, valid3, busy3, done3;

    int n_checks = 0;
    int n_pass   = 0;

    assign mux_z1 = sel1;
    assign mux_z3 = sel3;

    mux_scan_ctrl #(.INPUT_BIT_LENGTH(W), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop), .chan_mask(chan_mask),
        .sel(sel1), .mux_z(mux_z1), .out_data(data1), .out_chan(chan1),
        .out_valid(valid1), .out_ready(out_ready), .busy(busy1), .done(done1)
    );

    mux_scan_ctrl #(.INPUT_BIT_LENGTH(W), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stop(stop), .chan_mask(chan_mask),
        .sel(sel3), .mux_z(mux_z3), .out_data(data3), .out_chan(chan3),
        .out_valid(valid3), .out_ready(out_ready), .busy(busy3), .done(done3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sel1, data1, chan1, valid1, busy1, done1} !== '0)
            $display("FAIL reset_dut1: sel=%0d data=%0d chan=%0d v=%b busy=%b done=%b want all 0", sel1, data1, chan1, valid1, busy1, done1);
        else n_pass++;
        n_checks++;
        if ({sel3, data3, chan3, valid3, busy3, done3} !== '0)
            $display("FAIL reset_dut3: sel=%0d data=%0d chan=%0d v=%b busy=%b done=%b want all 0", sel3, data3, chan3, valid3, busy3, done3);
        else n_pass++;
        #5 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_mask();
        chan_mask = 16'h0000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b1)
            $display("FAIL zero_mask_pulse: busy=%b done=%b want busy=0 done=1", busy1, done1);
        else n_pass++;
        tick();
        n_checks++;
        if (done1 !== 1'b0) $display("FAIL zero_mask_single: done=%b want 0", done1);
        else n_pass++;
    endtask

    task automatic test_full_scan();
        int nsamp  = 0;
        int ndone  = 0;
        int last_v = -1;
        int done_c = -1;
        chan_mask = 16'hFFFF;
        out_ready = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (valid1) begin
                if (nsamp < 16) begin
                    n_checks++;
                    if (data1 !== 4'(nsamp) || chan1 !== 4'(nsamp))
                        $display("FAIL full_scan_sample%0d: data=%0d chan=%0d want %0d", nsamp, data1, chan1, nsamp);
                    else n_pass++;
                    last_v = c;
                end
                nsamp++;
            end
            if (done1) begin
                ndone++;
                done_c = c;
            end
            tick();
        end
`ifndef MUX_SCAN_CONTINUOUS_EN
        n_checks++;
        if (nsamp != 16) $display("FAIL full_scan_count: got %0d samples want 16", nsamp);
        else n_pass++;
        n_checks++;
        if (ndone != 1 || done_c != last_v + 1)
            $display("FAIL full_scan_done: pulses=%0d at cycle %0d want 1 at cycle %0d", ndone, done_c, last_v + 1);
        else n_pass++;
        n_checks++;
        if (busy1 !== 1'b0) $display("FAIL full_scan_idle: busy=%b want 0", busy1);
        else n_pass++;
`else
        n_checks++;
        if (nsamp != 20 || ndone != 0)
            $display("FAIL full_scan_wrap: samples=%0d done=%0d want 20 and 0", nsamp, ndone);
        else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0) $display("FAIL full_scan_stop: busy=%b want 0", busy1);
        else n_pass++;
`endif
    endtask

    task automatic test_settle3();
        logic [3:0] exp_ch [3];
        int i    = 0;
        int hold = 0;
        exp_ch = '{4'd0, 4'd2, 4'd15};
        chan_mask = 16'h8005;
        out_ready = 1'b1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 30 && i < 3; c++) begin
            if (valid3) begin
                n_checks++;
                if (chan3 !== exp_ch[i] || data3 !== exp_ch[i] || hold != 3)
                    $display("FAIL settle3_sample%0d: chan=%0d data=%0d settle=%0d want chan/data %0d settle 3", i, chan3, data3, hold, exp_ch[i]);
                else n_pass++;
                i++;
                hold = 0;
            end else if (busy3) begin
                n_checks++;
                if (sel3 !== exp_ch[i]) $display("FAIL settle3_sel: sel=%0d want %0d", sel3, exp_ch[i]);
                else n_pass++;
                hold++;
            end
            tick();
        end
        n_checks++;
        if (i != 3) $display("FAIL settle3_timeout: got %0d samples want 3", i);
        else n_pass++;
`ifndef MUX_SCAN_CONTINUOUS_EN
        n_checks++;
        if (done3 !== 1'b1 || busy3 !== 1'b0)
            $display("FAIL settle3_done: done=%b busy=%b want 1 and 0", done3, busy3);
        else n_pass++;
`else
        n_checks++;
        if (busy3 !== 1'b1 || sel3 !== 4'd0 || done3 !== 1'b0)
            $display("FAIL settle3_wrap: busy=%b sel=%0d done=%b want 1, 0, 0", busy3, sel3, done3);
        else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
`endif
        tick();
    endtask

    task automatic test_backpressure();
        bit got = 1'b0;
        chan_mask = 16'h0030;
        out_ready = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            if (valid1) got = 1'b1;
            else tick();
        end
        n_checks++;
        if (!got || chan1 !== 4'd4 || data1 !== 4'd4)
            $display("FAIL bp_first: valid=%b chan=%0d data=%0d want 1, 4, 4", valid1, chan1, data1);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                start1 = 1'b1;
                chan_mask = 16'h0001;
            end
            tick();
            start1 = 1'b0;
            n_checks++;
            if ({valid1, data1, chan1, sel1} !== {1'b1, 4'd4, 4'd4, 4'd4})
                $display("FAIL bp_stable%0d: v=%b data=%0d chan=%0d sel=%0d want 1,4,4,4", c, valid1, data1, chan1, sel1);
            else n_pass++;
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (valid1 !== 1'b0 || sel1 !== 4'd5 || busy1 !== 1'b1)
            $display("FAIL bp_advance: v=%b sel=%0d busy=%b want 0, 5, 1", valid1, sel1, busy1);
        else n_pass++;
        tick();
        n_checks++;
        if (valid1 !== 1'b1 || chan1 !== 4'd5) $display("FAIL bp_second: v=%b chan=%0d want 1, 5", valid1, chan1);
        else n_pass++;
        tick();
`ifndef MUX_SCAN_CONTINUOUS_EN
        n_checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) $display("FAIL bp_done: done=%b busy=%b want 1, 0", done1, busy1);
        else n_pass++;
`else
        n_checks++;
        if (sel1 !== 4'd4 || busy1 !== 1'b1) $display("FAIL bp_wrap: sel=%0d busy=%b want 4, 1", sel1, busy1);
        else n_pass++;
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0) $display("FAIL bp_end_idle: busy=%b want 0", busy1);
        else n_pass++;
    endtask

    task automatic test_stop_settle();
        bit found = 1'b0;
        chan_mask = 16'h0014;
        out_ready = 1'b1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (busy3 && !valid3 && sel3 == 4'd4) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found) $display("FAIL stop_reach_ch4: sel=%0d busy=%b want sel 4 in settle", sel3, busy3);
        else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy3 !== 1'b0 || valid3 !== 1'b0 || done3 !== 1'b0)
            $display("FAIL stop_idle: busy=%b v=%b done=%b want 0,0,0", busy3, valid3, done3);
        else n_pass++;
        tick();
        n_checks++;
        if (done3 !== 1'b0 || busy3 !== 1'b0) $display("FAIL stop_no_done: done=%b busy=%b want 0,0", done3, busy3);
        else n_pass++;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n_checks++;
        if (sel3 !== 4'd2 || busy3 !== 1'b1) $display("FAIL stop_rescan: sel=%0d busy=%b want 2, 1", sel3, busy3);
        else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset_hold();
        chan_mask = 16'h0100;
        out_ready = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        n_checks++;
        if (valid1 !== 1'b1 || chan1 !== 4'd8) $display("FAIL rst_hold_setup: v=%b chan=%0d want 1, 8", valid1, chan1);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sel1, data1, chan1, valid1, busy1, done1} !== '0)
            $display("FAIL rst_async: sel=%0d data=%0d chan=%0d v=%b busy=%b done=%b want all 0", sel1, data1, chan1, valid1, busy1, done1);
        else n_pass++;
        #2 rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL rst_wait_start: busy=%b done=%b want 0, 0", busy1, done1);
        else n_pass++;
    endtask

`ifdef MUX_SCAN_CONTINUOUS_EN
    task automatic test_continuous();
        int n = 0;
        int ndone = 0;
        chan_mask = 16'h0003;
        out_ready = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (valid1) begin
                n_checks++;
                if (chan1 !== 4'(n % 2)) $display("FAIL cont_seq%0d: chan=%0d want %0d", n, chan1, n % 2);
                else n_pass++;
                n++;
            end
            if (done1) ndone++;
            tick();
        end
        n_checks++;
        if (n != 8 || ndone != 0) $display("FAIL cont_count: samples=%0d done=%0d want 8, 0", n, ndone);
        else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL cont_stop: busy=%b done=%b want 0, 0", busy1, done1);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_mask();
        test_full_scan();
        test_settle3();
        test_backpressure();
        test_stop_settle();
        test_reset_hold();
`ifdef MUX_SCAN_CONTINUOUS_EN
        test_continuous();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter INPUT_BIT_LENGTH, default 1, giving the data width per channel of the downstream-fed mux.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, legal range 1..15, giving the cycles from a sel change to the data capture.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: a pulse that begins a scan when the block is idle.
REQ-006 SHALL have port stop, input, 1 bit: a pulse that aborts the scan.
REQ-007 SHALL have port chan_mask, input, 16 bits: enabled channels; bit n enables channel n.
REQ-008 SHALL have port sel, output, 4 bits: the channel select driven to the 16:1 mux.
REQ-009 SHALL have port mux_z, input, INPUT_BIT_LENGTH bits: the mux output.
REQ-010 SHALL have port out_data, output, INPUT_BIT_LENGTH bits: the captured sample.
REQ-011 SHALL have port out_chan, output, 4 bits: the channel index of out_data.
REQ-012 SHALL have port out_valid, input out_ready, 1 bit each: the output handshake.
REQ-013 SHALL have port busy, output, 1 bit, high when not IDLE; and port done, output, 1 bit, a one-cycle end-of-scan pulse.

Function
REQ-014 SHALL implement states IDLE, SETTLE, HOLD.
REQ-015 In IDLE, start=1 SHALL register chan_mask into an internal mask.
REQ-016 In IDLE with start=1 and a nonzero mask, the block SHALL load sel with the lowest enabled index, clear the settle counter and enter SETTLE.
REQ-017 start with chan_mask==0 SHALL stay IDLE and pulse done one cycle later.
REQ-018 SETTLE SHALL count cycles and, at the SETTLE_CYCLES-th edge after sel loaded, capture mux_z into out_data and sel into out_chan, set out_valid and enter HOLD.
REQ-019 HOLD SHALL keep out_valid, out_data and out_chan stable until out_valid&&out_ready.
REQ-020 On the handshake edge, out_valid SHALL drop unless a new capture occurs on the same edge; it never does, since settle is at least 1.
REQ-021 On that edge, sel SHALL advance to the next enabled index above the current one and the block SHALL enter SETTLE, with 0 cycles spent on masked channels.
REQ-022 If no enabled index lies above the current one, behaviour SHALL follow the configuration (REQ-030/031).
REQ-023 stop=1 in SETTLE or HOLD SHALL drop out_valid and enter IDLE on that edge, with no done pulse; a sample in HOLD is discarded.
REQ-024 stop in IDLE SHALL be ignored.
REQ-025 start while busy SHALL be ignored; chan_mask changes during a scan SHALL be ignored.
REQ-026 sel SHALL be registered and glitch-free, changing only on an entry to SETTLE.
REQ-027 The capture path SHALL take mux_z as registered-input-stable (the mux is combinational; settling is covered by SETTLE_CYCLES).

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, with sel=0, out_data=0, out_chan=0, out_valid=0, done=0, busy=0, the internal mask cleared and the settle counter 0.
REQ-029 Reset asserted mid-scan SHALL abandon the scan with no done pulse; after release the block SHALL wait for a new start.

Configuration
REQ-030 With macro MUX_SCAN_CONTINUOUS_EN defined, the handshake on the highest enabled channel SHALL wrap sel to the lowest enabled channel and re-enter SETTLE. Scanning continues until stop; done never pulses except for REQ-017.
REQ-031 Without MUX_SCAN_CONTINUOUS_EN, the handshake on the highest enabled channel SHALL enter IDLE and pulse done on that edge plus one cycle.

Verification
REQ-032 SETTLE_CYCLES=1, mask=16'hFFFF, out_ready=1, mux_z=sel value -> 16 samples 0..15, out_chan equal to the data, then a single done pulse.
REQ-033 mask=16'h8005, SETTLE_CYCLES=3 -> sel sequence 0,2,15, each sel held 3 cycles before out_valid, with 3 samples then done.
REQ-034 out_ready held 0 for 10 cycles in HOLD -> out_valid/out_data/out_chan/sel constant, then advance one cycle after out_ready=1.
REQ-035 stop in SETTLE on channel 4 -> IDLE next cycle, out_valid=0, no done; a subsequent start rescans from the lowest enabled channel.
REQ-036 rst_n low mid-HOLD -> all outputs 0 immediately, asynchronously; with MUX_SCAN_CONTINUOUS_EN and mask=16'h0003, the sequence 0,1,0,1... continues until stop.
